dsp_frame_accumulator: RTL and testbench

//  Downstream stage of the dynamic pre-add/sub -> multiply -> add DSP pipeline.
//  - Consumes the pipeline's signed (2*SIZEIN+1)-bit result stream.
//  - Sums FRAME_LEN consecutive samples into one frame sum (dot-product / FIR tap accumulation).
//  - Rounds and shifts the sum, saturates it to OUT_W bits, and offers it on a valid/ready

---
 rtl/dsp_frame_accumulator.sv | 113 +++++++++++
 tb/tb_dsp_frame_accumulator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_frame_accumulator.sv
// Frame accumulator for the DSP multiply-add result stream: sums FRAME_LEN samples,
// rounds half-up, shifts, saturates to OUT_W bits and presents the result on valid/ready.
module dsp_frame_accumulator #(
    parameter int SIZEIN    = 16,
    parameter int FRAME_LEN = 8,
    parameter int SHIFT     = 4,
    parameter int OUT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce,
    input  logic signed [2*SIZEIN:0]       in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           flush,
    output logic signed [OUT_W-1:0]        out_data,
    output logic                           out_sat,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(FRAME_LEN)-1:0]   frame_cnt
);

    localparam int IN_W  = 2*SIZEIN+1;
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int ACC_W = IN_W + CNT_W;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN-1);
    localparam logic signed [ACC_W:0] RND_V = ((ACC_W+1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic signed [OUT_W-1:0] out_data_reg, out_data_next;
    logic                    out_sat_reg, out_sat_next;
    logic                    out_valid_reg, out_valid_next;

    logic                    in_xfer, out_xfer, start_new, frame_done;
    logic signed [ACC_W-1:0] in_ext, sum;
    logic signed [ACC_W:0]   rnd_sum, rnd_shift;

    assign in_ready  = !out_valid_reg || out_ready;
    assign in_xfer   = ce && in_valid && in_ready;
    assign out_xfer  = ce && out_valid_reg && out_ready;

    // A flush with a coincident sample restarts the frame at that sample.
    assign start_new  = flush || (cnt_reg == '0);
    assign frame_done = in_xfer && !flush && (cnt_reg == LAST_CNT);

    assign in_ext    = {{CNT_W{in_data[IN_W-1]}}, in_data};
    assign sum       = start_new ? in_ext : acc_reg + in_ext;
    // One extra bit so the rounding constant cannot overflow the full-scale sum.
    assign rnd_sum   = {sum[ACC_W-1], sum} + RND_V;
    assign rnd_shift = rnd_sum >>> SHIFT;

    always_comb begin
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        out_data_next  = out_data_reg;
        out_sat_next   = out_sat_reg;
        out_valid_next = out_valid_reg;

        if (in_xfer) begin
            acc_next = sum;
            if (flush)
                cnt_next = CNT_W'(1);
            else if (cnt_reg == LAST_CNT)
                cnt_next = '0;
            else
                cnt_next = cnt_reg + CNT_W'(1);
        end else if (flush) begin
            cnt_next = '0;
        end

        if (frame_done) begin
            out_valid_next = 1'b1;
            if (rnd_shift > MAX_V) begin
                out_data_next = MAX_V[OUT_W-1:0];
                out_sat_next  = 1'b1;
            end else if (rnd_shift < MIN_V) begin
                out_data_next = MIN_V[OUT_W-1:0];
                out_sat_next  = 1'b1;
            end else begin
                out_data_next = rnd_shift[OUT_W-1:0];
                out_sat_next  = 1'b0;
            end
        end else if (out_xfer) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (ce) begin
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            out_data_reg  <= out_data_next;
            out_sat_reg   <= out_sat_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;
    assign out_valid = out_valid_reg;
    assign frame_cnt = cnt_reg;

endmodule

// File: tb/tb_dsp_frame_accumulator.sv
// Directed self-checking bench for dsp_frame_accumulator (SIZEIN=16, FRAME_LEN=4, SHIFT=2, OUT_W=16).
module tb_dsp_frame_accumulator;

    localparam int SIZEIN    = 16;
    localparam int FRAME_LEN = 4;
    localparam int SHIFT     = 2;
    localparam int OUT_W     = 16;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        ce;
    logic signed [2*SIZEIN:0]    in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        flush;
    logic signed [OUT_W-1:0]     out_data;
    logic                        out_sat;
    logic                        out_valid;
    logic                        out_ready;
    logic [1:0]                  frame_cnt;

    int checks = 0;
    int errors = 0;

    dsp_frame_accumulator #(
        .SIZEIN(SIZEIN), .FRAME_LEN(FRAME_LEN), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush),
        .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        in_data  = 33'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send4(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_sat !== 1'b0 || frame_cnt !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b data=%0d sat=%b cnt=%0d rdy=%b, required 0 0 0 0 1",
                     out_valid, out_data, out_sat, frame_cnt, in_ready);
        end
        $display("reset: valid=%b data=%0d cnt=%0d", out_valid, out_data, frame_cnt);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send4(10, 20, 30, 40);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sd25 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: valid=%b data=%0d sat=%b, required 1 25 0", out_valid, out_data, out_sat);
        end
        $display("basic 10,20,30,40: data=%0d sat=%b", out_data, out_sat);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_one_cycle: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_round_negative();
        send4(-1, -1, -1, -2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== -16'sd1 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL round_neg: valid=%b data=%0d sat=%b, required 1 -1 0", out_valid, out_data, out_sat);
        end
        $display("round -1,-1,-1,-2: data=%0d sat=%b", out_data, out_sat);
    endtask

    task automatic test_saturation();
        send4(1 << 20, 1 << 20, 1 << 20, 1 << 20);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sd32767 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: valid=%b data=%0d sat=%b, required 1 32767 1", out_valid, out_data, out_sat);
        end
        $display("sat +2^20 x4: data=%0d sat=%b", out_data, out_sat);
        send4(-(1 << 20), -(1 << 20), -(1 << 20), -(1 << 20));
        checks++;
        if (out_valid !== 1'b1 || out_data !== -16'sd32768 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg: valid=%b data=%0d sat=%b, required 1 -32768 1", out_valid, out_data, out_sat);
        end
        $display("sat -2^20 x4: data=%0d sat=%b", out_data, out_sat);
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send4(1, 2, 3, 4);
        in_valid = 1'b1; in_data = 33'sd50;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'sd3 || in_ready !== 1'b0 || frame_cnt !== 2'd0) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b data=%0d rdy=%b cnt=%0d, required 1 3 0 0",
                         i, out_valid, out_data, in_ready, frame_cnt);
            end
            $display("hold cycle %0d: data=%0d rdy=%b cnt=%0d", i, out_data, in_ready, frame_cnt);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || frame_cnt !== 2'd1) begin
            errors++;
            $display("FAIL release: valid=%b cnt=%0d, required 0 1", out_valid, frame_cnt);
        end
        $display("release: valid=%b cnt=%0d", out_valid, frame_cnt);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++;
        if (frame_cnt !== 2'd0) begin
            errors++;
            $display("FAIL flush_idle: cnt=%0d, required 0", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int exp_val;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            in_data = 33'(i);
            tick();
            exp_val = (i == 4) ? 3 : (i == 8) ? 7 : 11;
            checks++;
            if (out_valid !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL b2b_valid[%0d]: valid=%b, required %b", i, out_valid, (i % 4) == 0);
            end else if (out_valid && out_data !== 16'(exp_val)) begin
                errors++;
                $display("FAIL b2b_data[%0d]: data=%0d, required %0d", i, out_data, exp_val);
            end
            $display("b2b sample %0d: valid=%b data=%0d", i, out_valid, out_data);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic check_fresh(input string name, input int v, input int exp_val);
        send4(v, v, v, v);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'(exp_val)) begin
            errors++;
            $display("FAIL %s: valid=%b data=%0d, required 1 %0d", name, out_valid, out_data, exp_val);
        end
        $display("%s: data=%0d", name, out_data);
        tick();
    endtask

    task automatic test_mid_frame();
        out_ready = 1'b1;
        // reset mid-frame
        send(100); send(100);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (frame_cnt !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: cnt=%0d valid=%b, required 0 0", frame_cnt, out_valid);
        end
        check_fresh("after_rst", 4, 4);
        // flush mid-frame
        send(100); send(100);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++;
        if (frame_cnt !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_flush: cnt=%0d valid=%b, required 0 0", frame_cnt, out_valid);
        end
        check_fresh("after_flush", 4, 4);
        // flush with coincident sample
        send(100); send(100);
        flush = 1'b1; send(8); flush = 1'b0;
        checks++;
        if (frame_cnt !== 2'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_sample: cnt=%0d valid=%b, required 1 0", frame_cnt, out_valid);
        end
        send(8); send(8); send(8);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sd8) begin
            errors++;
            $display("FAIL flush_sample_result: valid=%b data=%0d, required 1 8", out_valid, out_data);
        end
        $display("flush+8 then 8,8,8: data=%0d", out_data);
        tick();
        // clock enable low mid-frame
        send(100); send(100);
        ce = 1'b0; in_valid = 1'b1; in_data = 33'sd7; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (frame_cnt !== 2'd2) begin
                errors++;
                $display("FAIL ce_freeze[%0d]: cnt=%0d, required 2", i, frame_cnt);
            end
        end
        ce = 1'b1; in_valid = 1'b0; flush = 1'b0;
        send(100); send(100);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sd100) begin
            errors++;
            $display("FAIL ce_resume: valid=%b data=%0d, required 1 100", out_valid, out_data);
        end
        $display("ce freeze then resume: data=%0d", out_data);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_negative();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
